multicycle_ctrl: RTL and testbench

//   Multi-cycle control FSM for the RV32 subset lw/sw/R-type/beq. Replaces the

---
 rtl/rv_ctrl_pkg.sv | 59 +++++
 rtl/multicycle_out_dec.sv | 69 ++++++
 rtl/multicycle_ctrl.sv | 96 +++++++++
 tb/tb_multicycle_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 (lw/sw/R-type/beq) controller.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8
    } state_e;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I      = 2'b00;
    localparam logic [1:0] IMM_S      = 2'b01;
    localparam logic [1:0] IMM_B      = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_FUNCT  = 2'b01;
    localparam logic [1:0] ALU_SUB    = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       ir_write;
        logic       mem_wri;
        logic       reg_wri;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [1:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_supported_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/multicycle_out_dec.sv
// Combinational state+op -> control-vector decoder for the multi-cycle controller.
module multicycle_out_dec
    import rv_ctrl_pkg::*;
(
    input  state_e      state_i,
    input  logic [6:0]  op_i,
    input  logic        zero_i,
    input  logic        mem_rdy_i,
    output ctrl_t       ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.adr_src    = 1'b0;
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.result_src = RES_ALU;
                ctrl_o.ir_write   = mem_rdy_i;
                ctrl_o.pc_write   = mem_rdy_i;
            end
            S_DECODE: begin
                // Branch target is precomputed here so BEQ only has to compare.
                ctrl_o.alu_src_a  = SRCA_OLDPC;
                ctrl_o.alu_src_b  = SRCB_IMM;
                ctrl_o.imm_src    = IMM_B;
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.illegal_op = !is_supported_op(op_i);
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a  = SRCA_RS1;
                ctrl_o.alu_src_b  = SRCB_IMM;
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.imm_src    = (op_i == OP_SW) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                ctrl_o.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.result_src = RES_MEM;
                ctrl_o.reg_wri    = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.mem_wri    = 1'b1;
            end
            S_EXECR: begin
                ctrl_o.alu_src_a  = SRCA_RS1;
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.alu_op     = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_wri    = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alu_src_a  = SRCA_RS1;
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.alu_op     = ALU_SUB;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.pc_write   = zero_i;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute over a shared ALU and memory port.
// States: FETCH/DECODE common; MEMADR->MEMREAD->MEMWB (lw), MEMADR->MEMWRITE (sw), EXECR->ALUWB, BEQ.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter bit WAIT_MEM = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             Memwri,
    output logic             Regwri,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       ALUop,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instret
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             mem_rdy;
    logic             retire;
    ctrl_t            ctrl;

    assign mem_rdy = WAIT_MEM ? mem_ready : 1'b1;

    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    retire  = 1'b1;
            S_MEMWRITE: begin
                if (mem_rdy) retire  = 1'b1;
                else         state_d = S_MEMWRITE;
            end
            S_EXECR:    state_d = S_ALUWB;
            S_ALUWB:    retire  = 1'b1;
            S_BEQ:      retire  = 1'b1;
            default:    state_d = S_FETCH;
        endcase
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    multicycle_out_dec u_out_dec (
        .state_i   (state_q),
        .op_i      (op),
        .zero_i    (zero),
        .mem_rdy_i (mem_rdy),
        .ctrl_o    (ctrl)
    );

    // Write-type enables are suppressed during reset so an abandoned access never commits.
    assign PCWrite    = ctrl.pc_write   & ~rst;
    assign IRWrite    = ctrl.ir_write   & ~rst;
    assign Memwri     = ctrl.mem_wri    & ~rst;
    assign Regwri     = ctrl.reg_wri    & ~rst;
    assign illegal_op = ctrl.illegal_op & ~rst;
    assign AdrSrc     = ctrl.adr_src;
    assign ResultSrc  = ctrl.result_src;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ImmSrc     = ctrl.imm_src;
    assign ALUop      = ctrl.alu_op;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors from an instruction-level model.
module tb_multicycle_ctrl;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_BEQ = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, IRWrite, Memwri, Regwri, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUop;
    logic [3:0] instret;

    multicycle_ctrl #(.CNT_W(4), .WAIT_MEM(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .Memwri     (Memwri),
        .Regwri     (Regwri),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUop      (ALUop),
        .illegal_op (illegal_op),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, mem_ready, zero, chk, ret;
        logic [6:0] op;
        logic       pcw, adr, irw, memw, regw, ill;
        logic [1:0] rs, sa, sb, imm, aluop;
        logic [3:0] cnt;
    } cyc_t;

    logic [19:0] sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [3:0]  model_cnt = '0;

    function automatic logic [19:0] pack(input cyc_t c);
        return {c.pcw, c.adr, c.irw, c.memw, c.regw, c.rs, c.sa, c.sb, c.imm, c.aluop, c.ill, c.cnt};
    endfunction

    // Inputs that the current phase ignores are randomised to show they have no effect.
    function automatic cyc_t blank();
        cyc_t c;
        c = '{default: '0};
        c.op        = 7'($urandom);
        c.zero      = 1'($urandom);
        c.mem_ready = 1'($urandom);
        c.chk       = 1'b1;
        return c;
    endfunction

    function automatic cyc_t force_rst(input cyc_t c);
        cyc_t r;
        r = c;
        r.rst = 1'b1; r.ret = 1'b0;
        r.pcw = 1'b0; r.irw = 1'b0; r.memw = 1'b0; r.regw = 1'b0; r.ill = 1'b0;
        return r;
    endfunction

    function automatic cyc_t fetch_ph(input logic rdy);
        cyc_t c;
        c = blank();
        c.rs = 2'b10; c.sb = 2'b10; c.mem_ready = rdy; c.pcw = rdy; c.irw = rdy;
        return c;
    endfunction

    task automatic issue(input cyc_t c);
        @(posedge clk);
        #1;
        rst = c.rst; op = c.op; zero = c.zero; mem_ready = c.mem_ready;
        c.cnt = model_cnt;
        if (c.chk) sb_q.push_back(pack(c));
        if (c.rst)      model_cnt = '0;
        else if (c.ret) model_cnt = model_cnt + 4'd1;
    endtask

    task automatic gen_instr(input logic [6:0] opc, input int fst, input int mst,
                             input logic z, input int abort_at);
        cyc_t q[$];
        cyc_t c;
        for (int i = 0; i <= fst; i++) q.push_back(fetch_ph(i == fst));
        c = blank(); c.op = opc; c.sa = 2'b01; c.sb = 2'b01; c.imm = 2'b10;
        c.ill = !(opc == T_LW || opc == T_SW || opc == T_R || opc == T_BEQ);
        q.push_back(c);
        if (opc == T_LW || opc == T_SW) begin
            c = blank(); c.op = opc; c.sa = 2'b10; c.sb = 2'b01;
            c.imm = (opc == T_SW) ? 2'b01 : 2'b00;
            q.push_back(c);
            for (int i = 0; i <= mst; i++) begin
                c = blank(); c.adr = 1'b1; c.mem_ready = (i == mst);
                if (opc == T_SW) begin c.memw = 1'b1; c.ret = (i == mst); end
                q.push_back(c);
            end
            if (opc == T_LW) begin
                c = blank(); c.rs = 2'b01; c.regw = 1'b1; c.ret = 1'b1;
                q.push_back(c);
            end
        end else if (opc == T_R) begin
            c = blank(); c.sa = 2'b10; c.sb = 2'b00; c.aluop = 2'b01;
            q.push_back(c);
            c = blank(); c.rs = 2'b00; c.regw = 1'b1; c.ret = 1'b1;
            q.push_back(c);
        end else if (opc == T_BEQ) begin
            c = blank(); c.sa = 2'b10; c.sb = 2'b00; c.aluop = 2'b10; c.rs = 2'b00;
            c.zero = z; c.pcw = z; c.ret = 1'b1;
            q.push_back(c);
        end
        if (abort_at >= 0 && abort_at < q.size()) begin
            while (q.size() > abort_at + 1) void'(q.pop_back());
            q[abort_at] = force_rst(q[abort_at]);
        end
        foreach (q[i]) issue(q[i]);
    endtask

    always @(negedge clk) begin
        logic [19:0] exp_v, act_v;
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            act_v = {PCWrite, AdrSrc, IRWrite, Memwri, Regwri, ResultSrc, ALUSrcA, ALUSrcB,
                     ImmSrc, ALUop, illegal_op, instret};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL ctrl_vec #%0d t=%0t: got %05h expected %05h", vectors, $time, act_v, exp_v);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        cyc_t c;
        logic [6:0] opc;
        int kind, fst, mst, ab;
        c = fetch_ph(1'b1); c.chk = 1'b0;
        issue(force_rst(c));
        issue(force_rst(fetch_ph(1'b1)));
        gen_instr(T_R,   0, 0, 1'b0, -1);
        gen_instr(T_LW,  0, 3, 1'b0, -1);
        gen_instr(T_BEQ, 0, 0, 1'b1, -1);
        gen_instr(T_BEQ, 0, 0, 1'b0, -1);
        gen_instr(T_SW,  0, 2, 1'b0, -1);
        gen_instr(7'b1111111, 0, 0, 1'b0, -1);
        for (int i = 0; i < 10; i++) gen_instr(T_R, 0, 0, 1'b0, -1);
        gen_instr(T_SW, 0, 2, 1'b0, 3);
        for (int i = 0; i < 16; i++) gen_instr(T_R, 0, 0, 1'b0, -1);
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1:    opc = T_LW;
                2, 3:    opc = T_SW;
                4, 5:    opc = T_R;
                6, 7:    opc = T_BEQ;
                default: begin
                    opc = 7'($urandom);
                    while (opc == T_LW || opc == T_SW || opc == T_R || opc == T_BEQ) opc = 7'($urandom);
                end
            endcase
            fst = $urandom_range(0, 2);
            mst = $urandom_range(0, 3);
            ab  = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 8) : -1;
            gen_instr(opc, fst, mst, 1'($urandom), ab);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
